// File: rtl/wb_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage_pipe
// Function : MEM->WB pipeline stage with valid/ready handshake, optional
//            two-entry skid buffer, flush and writeback-data selection.
// Revision : 1.0
// ============================================================================
module wb_stage_pipe #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_read_data,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_read_data,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_reg_write,
    output logic              out_mem_to_reg,
    output logic [DATA_W-1:0] out_wb_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] read_data;
        logic [DATA_W-1:0] alu_result;
        logic [RD_W-1:0]   rd;
        logic              reg_write;
        logic              mem_to_reg;
    } entry_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    entry_t           head_q, head_d;
    entry_t           skid_q, skid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             ready_en_q;

    entry_t w_in_entry;
    logic   w_push;
    logic   w_pop;
    logic   w_out_valid;
    logic   w_in_ready;

    // Writes to x0 are squashed at capture so the head never asserts a write to it.
    always_comb begin
        w_in_entry            = '0;
        w_in_entry.read_data  = in_read_data;
        w_in_entry.alu_result = in_alu_result;
        w_in_entry.rd         = in_rd;
        w_in_entry.reg_write  = in_reg_write && (in_rd != '0);
        w_in_entry.mem_to_reg = in_mem_to_reg;
    end

    assign w_out_valid = (state_q != ST_EMPTY) && !flush;

    generate
        if (SKID != 0) begin : g_skid
            // Registered-only ready: breaks the out_ready -> in_ready path.
            assign w_in_ready = ready_en_q && !flush && (state_q != ST_TWO);
        end else begin : g_single
            assign w_in_ready = ready_en_q && !flush && (!w_out_valid || out_ready);
        end
    endgenerate

    assign w_push = in_valid && w_in_ready;
    assign w_pop  = w_out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (w_push) begin
                    head_d  = w_in_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_push && w_pop) begin
                    head_d = w_in_entry;
                end else if (w_push) begin
                    skid_d  = w_in_entry;
                    state_d = ST_TWO;
                end else if (w_pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_pop) begin
                    head_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (w_out_valid && !out_ready && (stall_cnt_q != C_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + C_CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            head_q      <= '0;
            skid_q      <= '0;
            stall_cnt_q <= '0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            stall_cnt_q <= stall_cnt_d;
            ready_en_q  <= 1'b1;
        end
    end

    assign in_ready       = w_in_ready;
    assign out_valid      = w_out_valid;
    assign out_read_data  = head_q.read_data;
    assign out_alu_result = head_q.alu_result;
    assign out_rd         = head_q.rd;
    assign out_reg_write  = head_q.reg_write && w_out_valid;
    assign out_mem_to_reg = head_q.mem_to_reg;
    assign out_wb_data    = head_q.mem_to_reg ? head_q.read_data : head_q.alu_result;
    assign stall_cnt      = stall_cnt_q;

endmodule
`default_nettype wire
